// File: rtl/fp_pkg.sv
// Shared floating-point field definitions and pack/unpack helpers
// for the FP multiply-add and divide datapath blocks.
package fp_pkg;

  localparam int FP_EXP   = 8;
  localparam int FP_MNT   = 23;
  localparam int FP_W     = 1 + FP_EXP + FP_MNT;
  localparam int EXP_BASE = (1 << (FP_EXP - 1)) - 1;

  typedef struct packed {
    logic              sig;
    logic [FP_EXP-1:0] exp;
    logic [FP_MNT-1:0] mnt;
  } fp_fields_t;

  function automatic fp_fields_t fp_unpack(input logic [FP_W-1:0] v);
    return fp_fields_t'(v);
  endfunction

  function automatic logic [FP_W-1:0] fp_pack(input logic              s,
                                               input logic [FP_EXP-1:0] e,
                                               input logic [FP_MNT-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fp_div_step.sv
// One radix-2 restoring division step: compare, conditionally subtract,
// shift the partial remainder left and emit one quotient bit.
module fp_div_step #(
  parameter int W = 25
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] div,
  output logic [W-1:0] rem_next,
  output logic         q
);

  logic [W-1:0] diff;

  always_comb begin
    diff = rem - div;
    if (rem >= div) begin
      rem_next = {diff[W-2:0], 1'b0};
      q        = 1'b1;
    end else begin
      rem_next = {rem[W-2:0], 1'b0};
      q        = 1'b0;
    end
  end

endmodule

// File: rtl/fp_div.sv
// Iterative floating-point divider (odata = idataA / idataB), one quotient
// bit per cycle, with valid/ready on both sides and a global stall enable.
//
// state  | meaning
// IDLE   | waiting for an operand pair; in_ready high
// DIVIDE | restoring division, one quotient bit per cycle
// NORM   | normalize quotient, compute exponent, register result
// DONE   | result presented; wait for out_ready
import fp_pkg::*;

module fp_div #(
  parameter int I_EXP      = FP_EXP,
  parameter int I_MNT      = FP_MNT,
  parameter int DATA_WIDTH = 1 + I_EXP + I_MNT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] idataA,
  input  logic [DATA_WIDTH-1:0] idataB,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  div_by_zero
);

  localparam int Q_BITS = I_MNT + 2;
  localparam int CNT_W  = $clog2(Q_BITS);
  localparam logic [CNT_W-1:0]       CNT_LOAD  = CNT_W'(Q_BITS - 1);
  localparam logic [I_MNT-1:0]       MNT_QNAN  = {1'b1, {(I_MNT-1){1'b0}}};
  localparam logic signed [I_EXP+1:0] EXP_BIAS = (I_EXP+2)'(EXP_BASE);
  localparam logic signed [I_EXP+1:0] EXP_MAX  = (I_EXP+2)'((1 << I_EXP) - 1);
  localparam logic signed [I_EXP+1:0] ONE_S    = (I_EXP+2)'(1);
  localparam logic signed [I_EXP+1:0] ZERO_S   = '0;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} fp_div_state_e;

  fp_div_state_e state;

  fp_fields_t fa, fb;
  logic       sgn;

  logic              sign_q;
  logic [I_EXP-1:0]  exp_a, exp_b;
  logic [Q_BITS-1:0] mant_b;
  logic [Q_BITS-1:0] rem, rem_next;
  logic [Q_BITS-1:0] quo;
  logic              q_bit;
  logic [CNT_W-1:0]  cnt;
  logic              out_valid_q;

  logic                  spec_hit;
  logic                  spec_dbz;
  logic [DATA_WIDTH-1:0] spec_res;

  logic signed [I_EXP+1:0] e_raw, e_adj;
  logic [I_MNT-1:0]        norm_mnt;
  logic [DATA_WIDTH-1:0]   norm_res;

  assign fa  = fp_unpack(idataA);
  assign fb  = fp_unpack(idataB);
  assign sgn = fa.sig ^ fb.sig;

  // Handshakes are suppressed while stalled so neither side sees a transfer.
  assign in_ready  = enable & (state == IDLE);
  assign out_valid = enable & out_valid_q;

  always_comb begin
    spec_hit = 1'b1;
    spec_dbz = 1'b0;
    spec_res = '0;
    if (fb.exp == '0) begin
      spec_res = fp_pack(sgn, '1, '0);
      spec_dbz = 1'b1;
    end else if (fa.exp == '1 || fb.exp == '1) begin
      spec_res = fp_pack(1'b0, '1, MNT_QNAN);
    end else if (fa.exp == '0) begin
      spec_res = fp_pack(sgn, '0, '0);
    end else begin
      spec_hit = 1'b0;
    end
  end

  fp_div_step #(.W(Q_BITS)) u_step (
    .rem      (rem),
    .div      (mant_b),
    .rem_next (rem_next),
    .q        (q_bit)
  );

  // Quotient lies in [0.5, 2); a clear integer bit costs one exponent step.
  always_comb begin
    e_raw = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + EXP_BIAS;
    if (quo[Q_BITS-1]) begin
      e_adj    = e_raw;
      norm_mnt = quo[Q_BITS-2 -: I_MNT];
    end else begin
      e_adj    = e_raw - ONE_S;
      norm_mnt = quo[Q_BITS-3 -: I_MNT];
    end
    if (e_adj >= EXP_MAX) begin
      norm_res = fp_pack(sign_q, '1, '0);
    end else if (e_adj <= ZERO_S) begin
      norm_res = fp_pack(sign_q, '0, '0);
    end else begin
      norm_res = fp_pack(sign_q, e_adj[I_EXP-1:0], norm_mnt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sign_q      <= 1'b0;
      exp_a       <= '0;
      exp_b       <= '0;
      mant_b      <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      odata       <= '0;
      div_by_zero <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= sgn;
            exp_a  <= fa.exp;
            exp_b  <= fb.exp;
            rem    <= {1'b0, 1'b1, fa.mnt};
            mant_b <= {1'b0, 1'b1, fb.mnt};
            cnt    <= CNT_LOAD;
            if (spec_hit) begin
              odata       <= spec_res;
              div_by_zero <= spec_dbz;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem <= rem_next;
          quo <= {quo[Q_BITS-2:0], q_bit};
          if (cnt == '0) state <= NORM;
          else           cnt   <= cnt - 1'b1;
        end
        NORM: begin
          odata       <= norm_res;
          div_by_zero <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
